guess_controller: RTL and testbench

GUESS_CONTROLLER -- requirements
Module: guess_controller

---
 rtl/mastermind_pkg.sv | 17 +
 rtl/guess_controller_if.sv | 26 ++
 rtl/code_entry.sv | 40 ++++
 rtl/guess_controller.sv | 132 +++++++++++++
 tb/tb_guess_controller.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/mastermind_pkg.sv
// Shared types and sizing for the guess controller: FSM states and code geometry.
package mastermind_pkg;

  localparam int LETTER_W  = 3;
  localparam int NUM_SLOTS = 4;
  localparam int CODE_W    = 12;
  localparam int SLOT_W    = 2;

  typedef enum logic [2:0] {
    ST_SECRET,
    ST_GUESS,
    ST_CHECK,
    ST_WIN,
    ST_LOSE
  } state_t;

endpackage

// File: rtl/guess_controller_if.sv
// Player-facing signal bundle of the guess controller.
interface guess_controller_if;
  import mastermind_pkg::*;

  logic [LETTER_W-1:0] letter_in;
  logic                enter;
  logic                restart;
  logic [CODE_W-1:0]   secret_val;
  logic [CODE_W-1:0]   guess_val;
  logic                game_over;
  logic                win;
  logic [3:0]          attempts_left;
  logic [SLOT_W-1:0]   slot_idx;
  logic                check_pulse;

  modport master (
    output letter_in, enter, restart,
    input  secret_val, guess_val, game_over, win, attempts_left, slot_idx, check_pulse
  );

  modport slave (
    input  letter_in, enter, restart,
    output secret_val, guess_val, game_over, win, attempts_left, slot_idx, check_pulse
  );

endinterface

// File: rtl/code_entry.sv
// Four-slot letter register; slot 0 is the most significant letter of o_code.
module code_entry
  import mastermind_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                i_clr,
  input  logic                i_we,
  input  logic                i_clr_rest,
  input  logic [SLOT_W-1:0]   i_idx,
  input  logic [LETTER_W-1:0] i_letter,
  output logic [CODE_W-1:0]   o_code
);

  logic [0:NUM_SLOTS-1][LETTER_W-1:0] r_slots;
  logic [0:NUM_SLOTS-1][LETTER_W-1:0] w_slots_nxt;

  // Write the indexed slot; optionally wipe the slots above it in the same cycle.
  always_comb begin
    w_slots_nxt = r_slots;
    if (i_we) begin
      for (int unsigned j = 0; j < NUM_SLOTS; j++) begin
        if (SLOT_W'(j) == i_idx)
          w_slots_nxt[SLOT_W'(j)] = i_letter;
        else if (i_clr_rest && (SLOT_W'(j) > i_idx))
          w_slots_nxt[SLOT_W'(j)] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || i_clr)
      r_slots <= '0;
    else
      r_slots <= w_slots_nxt;
  end

  assign o_code = r_slots;

endmodule

// File: rtl/guess_controller.sv
// Code-breaking game controller: secret entry, guess entry, one-cycle check, win/lose.
module guess_controller
  import mastermind_pkg::*;
#(
  parameter int unsigned MAX_ATTEMPTS = 8
) (
  input logic               clk,
  input logic               reset,
  guess_controller_if.slave bus
);

  localparam logic [3:0] ATT_INIT = 4'(MAX_ATTEMPTS);

  state_t            r_state, w_state_nxt;
  logic [SLOT_W-1:0] r_slot, w_slot_nxt;
  logic [3:0]        r_att, w_att_nxt;
  logic              r_game_over, w_game_over_nxt;
  logic              r_win, w_win_nxt;

  logic              w_sec_we, w_sec_clr;
  logic              w_gss_we, w_gss_clr, w_gss_clr_rest;
  logic [CODE_W-1:0] w_secret, w_guess;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_SECRET;
      r_slot      <= '0;
      r_att       <= ATT_INIT;
      r_game_over <= 1'b0;
      r_win       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_slot      <= w_slot_nxt;
      r_att       <= w_att_nxt;
      r_game_over <= w_game_over_nxt;
      r_win       <= w_win_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_slot_nxt      = r_slot;
    w_att_nxt       = r_att;
    w_game_over_nxt = r_game_over;
    w_win_nxt       = r_win;
    w_sec_we        = 1'b0;
    w_sec_clr       = 1'b0;
    w_gss_we        = 1'b0;
    w_gss_clr       = 1'b0;
    w_gss_clr_rest  = 1'b0;
    if (bus.restart) begin
      w_state_nxt     = ST_SECRET;
      w_slot_nxt      = '0;
      w_att_nxt       = ATT_INIT;
      w_game_over_nxt = 1'b0;
      w_win_nxt       = 1'b0;
      w_sec_clr       = 1'b1;
      w_gss_clr       = 1'b1;
    end else begin
      unique case (r_state)
        ST_SECRET: if (bus.enter) begin
          w_sec_we = 1'b1;
          if (r_slot == SLOT_W'(NUM_SLOTS - 1)) begin
            w_state_nxt = ST_GUESS;
            w_slot_nxt  = '0;
            w_gss_clr   = 1'b1;
          end else begin
            w_slot_nxt = r_slot + 1'b1;
          end
        end
        // slot_idx holds at 3 through CHECK; it only returns to 0 on re-entering GUESS.
        ST_GUESS: if (bus.enter) begin
          w_gss_we       = 1'b1;
          w_gss_clr_rest = (r_slot == '0);
          if (r_slot == SLOT_W'(NUM_SLOTS - 1))
            w_state_nxt = ST_CHECK;
          else
            w_slot_nxt = r_slot + 1'b1;
        end
        ST_CHECK: begin
          if (w_guess == w_secret) begin
            w_state_nxt     = ST_WIN;
            w_game_over_nxt = 1'b1;
            w_win_nxt       = 1'b1;
          end else begin
            w_att_nxt = r_att - 4'd1;
            if (r_att == 4'd1) begin
              w_state_nxt     = ST_LOSE;
              w_game_over_nxt = 1'b1;
            end else begin
              w_state_nxt = ST_GUESS;
              w_slot_nxt  = '0;
            end
          end
        end
        ST_WIN, ST_LOSE: ;
        default: w_state_nxt = ST_SECRET;
      endcase
    end
  end

  code_entry u_secret (
    .clk        (clk),
    .reset      (reset),
    .i_clr      (w_sec_clr),
    .i_we       (w_sec_we),
    .i_clr_rest (1'b0),
    .i_idx      (r_slot),
    .i_letter   (bus.letter_in),
    .o_code     (w_secret)
  );

  code_entry u_guess (
    .clk        (clk),
    .reset      (reset),
    .i_clr      (w_gss_clr),
    .i_we       (w_gss_we),
    .i_clr_rest (w_gss_clr_rest),
    .i_idx      (r_slot),
    .i_letter   (bus.letter_in),
    .o_code     (w_guess)
  );

  assign bus.secret_val    = w_secret;
  assign bus.guess_val     = w_guess;
  assign bus.game_over     = r_game_over;
  assign bus.win           = r_win;
  assign bus.attempts_left = r_att;
  assign bus.slot_idx      = r_slot;
  assign bus.check_pulse   = (r_state == ST_CHECK);

endmodule

// File: tb/tb_guess_controller.sv
// Directed bench for guess_controller: one 8-attempt and one 2-attempt instance share stimulus.
module tb_guess_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] letter_in = '0;
  logic       enter = 1'b0;
  logic       restart = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  guess_controller_if bus8 ();
  guess_controller_if bus2 ();

  assign bus8.letter_in = letter_in;
  assign bus8.enter     = enter;
  assign bus8.restart   = restart;
  assign bus2.letter_in = letter_in;
  assign bus2.enter     = enter;
  assign bus2.restart   = restart;

  guess_controller #(.MAX_ATTEMPTS(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));
  guess_controller #(.MAX_ATTEMPTS(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  typedef struct {
    logic        rs;
    logic        en;
    logic [2:0]  l;
    logic [11:0] sec;
    logic [11:0] gss;
    logic [1:0]  slot;
    logic [3:0]  att;
    logic        go;
    logic        win;
    logic        cp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rs, en, input logic [2:0] l, input logic [11:0] sec, gss,
                     input logic [1:0] slot, input logic [3:0] att, input logic go, win, cp);
    vec_t v;
    v.rs = rs; v.en = en; v.l = l; v.sec = sec; v.gss = gss;
    v.slot = slot; v.att = att; v.go = go; v.win = win; v.cp = cp;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic rs, en, input logic [2:0] l);
    @(negedge clk);
    restart   = rs;
    enter     = en;
    letter_in = l;
    @(posedge clk);
    #1;
    restart = 1'b0;
    enter   = 1'b0;
  endtask

  task automatic check8(input string t, input logic [11:0] sec, gss, input logic [1:0] slot,
                        input logic [3:0] att, input logic go, win, cp);
    chk({t, ".sec8"},  32'(bus8.secret_val),    32'(sec));
    chk({t, ".gss8"},  32'(bus8.guess_val),     32'(gss));
    chk({t, ".slot8"}, 32'(bus8.slot_idx),      32'(slot));
    chk({t, ".att8"},  32'(bus8.attempts_left), 32'(att));
    chk({t, ".go8"},   32'(bus8.game_over),     32'(go));
    chk({t, ".win8"},  32'(bus8.win),           32'(win));
    chk({t, ".cp8"},   32'(bus8.check_pulse),   32'(cp));
  endtask

  task automatic check2(input string t, input logic [11:0] sec, gss, input logic [1:0] slot,
                        input logic [3:0] att, input logic go, win, cp);
    chk({t, ".sec2"},  32'(bus2.secret_val),    32'(sec));
    chk({t, ".gss2"},  32'(bus2.guess_val),     32'(gss));
    chk({t, ".slot2"}, 32'(bus2.slot_idx),      32'(slot));
    chk({t, ".att2"},  32'(bus2.attempts_left), 32'(att));
    chk({t, ".go2"},   32'(bus2.game_over),     32'(go));
    chk({t, ".win2"},  32'(bus2.win),           32'(win));
    chk({t, ".cp2"},   32'(bus2.check_pulse),   32'(cp));
  endtask

  task automatic enter_code(input logic [2:0] a, b, c, d);
    step(1'b0, 1'b1, a);
    step(1'b0, 1'b1, b);
    step(1'b0, 1'b1, c);
    step(1'b0, 1'b1, d);
  endtask

  initial begin
    // rs en l   secret   guess    slot att go win cp
    add(0, 1, 5, 12'hA00, 12'h000, 1, 8, 0, 0, 0);
    add(0, 1, 2, 12'hA80, 12'h000, 2, 8, 0, 0, 0);
    add(0, 1, 7, 12'hAB8, 12'h000, 3, 8, 0, 0, 0);
    add(0, 1, 1, 12'hAB9, 12'h000, 0, 8, 0, 0, 0);
    add(0, 1, 1, 12'hAB9, 12'h200, 1, 8, 0, 0, 0);
    add(0, 1, 1, 12'hAB9, 12'h240, 2, 8, 0, 0, 0);
    add(0, 1, 1, 12'hAB9, 12'h248, 3, 8, 0, 0, 0);
    add(0, 1, 1, 12'hAB9, 12'h249, 3, 8, 0, 0, 1);
    add(0, 1, 6, 12'hAB9, 12'h249, 0, 7, 0, 0, 0);
    add(0, 1, 3, 12'hAB9, 12'h600, 1, 7, 0, 0, 0);
    add(0, 0, 0, 12'hAB9, 12'h600, 1, 7, 0, 0, 0);
    add(0, 1, 2, 12'hAB9, 12'h680, 2, 7, 0, 0, 0);
    add(1, 1, 7, 12'h000, 12'h000, 0, 8, 0, 0, 0);
    add(0, 1, 5, 12'hA00, 12'h000, 1, 8, 0, 0, 0);
    add(0, 1, 2, 12'hA80, 12'h000, 2, 8, 0, 0, 0);
    add(0, 1, 7, 12'hAB8, 12'h000, 3, 8, 0, 0, 0);
    add(0, 1, 1, 12'hAB9, 12'h000, 0, 8, 0, 0, 0);
    add(0, 1, 5, 12'hAB9, 12'hA00, 1, 8, 0, 0, 0);
    add(0, 1, 2, 12'hAB9, 12'hA80, 2, 8, 0, 0, 0);
    add(0, 1, 7, 12'hAB9, 12'hAB8, 3, 8, 0, 0, 0);
    add(0, 1, 1, 12'hAB9, 12'hAB9, 3, 8, 0, 0, 1);
    add(0, 0, 0, 12'hAB9, 12'hAB9, 3, 8, 1, 1, 0);
    add(0, 1, 4, 12'hAB9, 12'hAB9, 3, 8, 1, 1, 0);
    add(0, 0, 0, 12'hAB9, 12'hAB9, 3, 8, 1, 1, 0);
    add(1, 0, 0, 12'h000, 12'h000, 0, 8, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    check8("reset", 12'h000, 12'h000, 0, 8, 0, 0, 0);
    check2("reset", 12'h000, 12'h000, 0, 2, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].rs, vecs[i].en, vecs[i].l);
      check8($sformatf("vec%0d", i), vecs[i].sec, vecs[i].gss, vecs[i].slot,
             vecs[i].att, vecs[i].go, vecs[i].win, vecs[i].cp);
    end

    // Two wrong guesses exhaust the 2-attempt instance.
    enter_code(5, 2, 7, 1);
    enter_code(1, 1, 1, 1);
    check2("lose.chk1", 12'hAB9, 12'h249, 3, 2, 0, 0, 1);
    step(0, 0, 0);
    check2("lose.mid", 12'hAB9, 12'h249, 0, 1, 0, 0, 0);
    enter_code(0, 0, 0, 0);
    check2("lose.chk2", 12'hAB9, 12'h000, 3, 1, 0, 0, 1);
    step(0, 0, 0);
    check2("lose.end", 12'hAB9, 12'h000, 3, 0, 1, 0, 0);
    check8("lose.dut8", 12'hAB9, 12'h000, 0, 6, 0, 0, 0);
    step(0, 1, 6);
    check2("lose.hold", 12'hAB9, 12'h000, 3, 0, 1, 0, 0);
    check8("lose.dut8e", 12'hAB9, 12'hC00, 1, 6, 0, 0, 0);

    // Reset asserted while in CHECK drops the pending decrement.
    step(1, 0, 0);
    enter_code(5, 2, 7, 1);
    enter_code(1, 1, 1, 1);
    check8("rstchk.pre", 12'hAB9, 12'h249, 3, 8, 0, 0, 1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check8("rstchk.post", 12'h000, 12'h000, 0, 8, 0, 0, 0);
    check2("rstchk.post", 12'h000, 12'h000, 0, 2, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    step(0, 0, 0);
    check8("rstchk.idle", 12'h000, 12'h000, 0, 8, 0, 0, 0);
    step(0, 1, 3);
    check8("rstchk.sec", 12'h600, 12'h000, 1, 8, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
